// File: rtl/token_ring_counter_if.sv
// Board-facing signal bundle for token_ring_counter: button, mode and display
// controls in, display pins and ring status out.
interface token_ring_counter_if #(
    parameter int DISPLAY_WIDTH = 8,
    parameter int STAGES        = 3,
    parameter int LAP_WIDTH     = 8
);
    localparam int SEL_WIDTH = $clog2(STAGES);

    logic                     start_btn;
    logic                     step_mode;
    logic [SEL_WIDTH-1:0]     disp_sel;
    logic [DISPLAY_WIDTH-1:0] output_pins;
    logic [STAGES-1:0]        trace_req;
    logic [LAP_WIDTH-1:0]     lap_cnt;
    logic                     running;

    modport master (
        output start_btn, step_mode, disp_sel,
        input  output_pins, trace_req, lap_cnt, running
    );

    modport slave (
        input  start_btn, step_mode, disp_sel,
        output output_pins, trace_req, lap_cnt, running
    );
endinterface

// File: rtl/token_ring_counter.sv
// Ring of STAGES counting stages passing one token over registered 4-phase
// req/ack links; each stage adds STEP on receive. Start button injects/advances.
module token_ring_counter #(
    parameter int WIDTH         = 25,
    parameter int DISPLAY_WIDTH = 8,
    parameter int STAGES        = 3,
    parameter int STEP          = 1,
    parameter int HOLD_CYCLES   = 0,
    parameter int LAP_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    token_ring_counter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACKED,
        ST_HOLD,
        ST_REQ
    } stage_state_e;

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ENTRY = (HOLD_CYCLES == 0) ? '0 : HOLD_W'(1);
    localparam logic [WIDTH-1:0]  STEP_W     = WIDTH'(STEP);

    function automatic int prev_idx(input int k);
        return (k == 0) ? STAGES - 1 : k - 1;
    endfunction

    stage_state_e          state    [STAGES];
    logic [WIDTH-1:0]      data     [STAGES];
    logic [HOLD_W-1:0]     hold_cnt [STAGES];
    logic [STAGES-1:0]     req;
    // ack[k] is owned by stage k+1 and answers req[k].
    logic [STAGES-1:0]     ack;
    logic [STAGES-1:0]     trace_q;
    logic [LAP_WIDTH-1:0]  lap_q;
    logic                  running_q;
    logic                  advance_pending;

    logic btn_meta, btn_sync, btn_sync_prev;
    logic start_edge;
    logic go;

    // Button is active-low; flops reset to the released level so reset never fakes a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta      <= 1'b1;
            btn_sync      <= 1'b1;
            btn_sync_prev <= 1'b1;
        end else begin
            btn_meta      <= bus.start_btn;
            btn_sync      <= btn_meta;
            btn_sync_prev <= btn_sync;
        end
    end

    assign start_edge = btn_sync_prev & ~btn_sync;
    assign go         = ~bus.step_mode | advance_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the per-stage arrays are tiny register files, so they are reset
            // explicitly; a restart must always begin from data 0.
            for (int k = 0; k < STAGES; k++) begin
                state[k]    <= ST_EMPTY;
                data[k]     <= '0;
                hold_cnt[k] <= '0;
            end
            req             <= '0;
            ack             <= '0;
            trace_q         <= '0;
            lap_q           <= '0;
            running_q       <= 1'b0;
            advance_pending <= 1'b0;
        end else begin
            // NOTE: every state register uses <= so all stages see each other's
            // pre-edge values, which is what makes each link a clean registered handshake.
            for (int k = 0; k < STAGES; k++) begin
                unique case (state[k])
                    ST_EMPTY: begin
                        if (k == 0 && start_edge && !running_q) begin
                            state[k]    <= ST_HOLD;
                            data[k]     <= '0;
                            hold_cnt[k] <= '0;
                        end else if (req[prev_idx(k)]) begin
                            data[k]          <= data[prev_idx(k)] + STEP_W;
                            ack[prev_idx(k)] <= 1'b1;
                            state[k]         <= ST_ACKED;
                            if (k == 0) lap_q <= lap_q + 1'b1;
                        end
                    end
                    ST_ACKED: begin
                        // The ack drop counts as the first hold cycle, giving a hop of
                        // 3 + HOLD_CYCLES from req rise to req rise.
                        if (!req[prev_idx(k)]) begin
                            ack[prev_idx(k)] <= 1'b0;
                            hold_cnt[k]      <= HOLD_ENTRY;
                            if (HOLD_CYCLES == 0 && go) begin
                                req[k]     <= 1'b1;
                                trace_q[k] <= 1'b1;
                                state[k]   <= ST_REQ;
                                if (bus.step_mode) advance_pending <= 1'b0;
                            end else begin
                                state[k] <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (hold_cnt[k] == HOLD_LAST) begin
                            if (go) begin
                                req[k]     <= 1'b1;
                                trace_q[k] <= 1'b1;
                                state[k]   <= ST_REQ;
                                if (bus.step_mode) advance_pending <= 1'b0;
                            end
                        end else begin
                            hold_cnt[k] <= hold_cnt[k] + 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (ack[k]) begin
                            req[k]   <= 1'b0;
                            state[k] <= ST_EMPTY;
                        end
                    end
                    default: state[k] <= ST_EMPTY;
                endcase
            end

            // A press landing in the same cycle as a consumed advance still counts.
            if (start_edge) begin
                if (!running_q)          running_q       <= 1'b1;
                else if (bus.step_mode)  advance_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: default first so unmatched disp_sel values drive 0 instead of a latch.
        bus.output_pins = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (int'(bus.disp_sel) == k) bus.output_pins = data[k][WIDTH-1 -: DISPLAY_WIDTH];
        end
    end

    assign bus.trace_req = trace_q;
    assign bus.lap_cnt   = lap_q;
    assign bus.running   = running_q;
endmodule

// File: tb/tb_token_ring_counter.sv
// Bench for token_ring_counter: three parameterisations share one stimulus stream
// and are compared every cycle against a token-level schedule model.
module tb_token_ring_counter;
    localparam int NI = 3;
    localparam int S  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b1;
    logic       step_mode = 1'b0;
    logic [1:0] disp_sel  = 2'd0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a: WIDTH 8, no hold; b: WIDTH 4 (wrap); c: WIDTH 8, HOLD_CYCLES 5
    token_ring_counter_if #(.DISPLAY_WIDTH(8), .STAGES(S), .LAP_WIDTH(8)) if_a ();
    token_ring_counter_if #(.DISPLAY_WIDTH(4), .STAGES(S), .LAP_WIDTH(8)) if_b ();
    token_ring_counter_if #(.DISPLAY_WIDTH(8), .STAGES(S), .LAP_WIDTH(8)) if_c ();

    assign if_a.start_btn = start_btn; assign if_a.step_mode = step_mode; assign if_a.disp_sel = disp_sel;
    assign if_b.start_btn = start_btn; assign if_b.step_mode = step_mode; assign if_b.disp_sel = disp_sel;
    assign if_c.start_btn = start_btn; assign if_c.step_mode = step_mode; assign if_c.disp_sel = disp_sel;

    token_ring_counter #(.WIDTH(8), .DISPLAY_WIDTH(8), .STAGES(S), .STEP(1), .HOLD_CYCLES(0), .LAP_WIDTH(8))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    token_ring_counter #(.WIDTH(4), .DISPLAY_WIDTH(4), .STAGES(S), .STEP(1), .HOLD_CYCLES(0), .LAP_WIDTH(8))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    token_ring_counter #(.WIDTH(8), .DISPLAY_WIDTH(8), .STAGES(S), .STEP(1), .HOLD_CYCLES(5), .LAP_WIDTH(8))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic [7:0] o_out [NI];
    logic [7:0] o_lap [NI];
    logic [2:0] o_trc [NI];
    logic       o_run [NI];
    assign o_out[0] = if_a.output_pins;         assign o_out[1] = {4'b0, if_b.output_pins};
    assign o_out[2] = if_c.output_pins;
    assign o_lap[0] = if_a.lap_cnt;  assign o_lap[1] = if_b.lap_cnt;  assign o_lap[2] = if_c.lap_cnt;
    assign o_trc[0] = if_a.trace_req; assign o_trc[1] = if_b.trace_req; assign o_trc[2] = if_c.trace_req;
    assign o_run[0] = if_a.running;  assign o_run[1] = if_b.running;  assign o_run[2] = if_c.running;

    function automatic int hold_of(input int i);
        return (i == 2) ? 5 : 0;
    endfunction
    function automatic int mod_of(input int i);
        return (i == 1) ? 16 : 256;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Token model: the holder stage may pass the token once its ready time has come
    // and it is allowed to go; the receiver latches one cycle after the pass.
    bit       m_run   [NI];
    int       m_hold  [NI];
    int       m_ready [NI];
    bit       m_fly   [NI];
    int       m_latch [NI];
    int       m_data  [NI][S];
    int       m_lap   [NI];
    bit [2:0] m_trace [NI];
    bit       m_pend  [NI];
    int       press_at = -1;
    bit       btn_q = 1'b1;
    bit       sm_q  = 1'b0;

    task automatic model_step(input int n);
        bit act;
        int dst;
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_run[i] = 0; m_hold[i] = 0; m_ready[i] = 0; m_fly[i] = 0; m_latch[i] = 0;
                m_lap[i] = 0; m_trace[i] = '0; m_pend[i] = 0;
                for (int s = 0; s < S; s++) m_data[i][s] = 0;
            end
            press_at = -1;
            btn_q    = 1'b1;
            sm_q     = step_mode;
        end else begin
            act = (press_at == n);
            for (int i = 0; i < NI; i++) begin
                if (m_fly[i] && m_latch[i] == n) begin
                    dst = (m_hold[i] + 1) % S;
                    m_data[i][dst] = (m_data[i][m_hold[i]] + 1) % mod_of(i);
                    if (dst == 0) m_lap[i] = (m_lap[i] + 1) % 256;
                    m_hold[i]  = dst;
                    m_fly[i]   = 0;
                    m_ready[i] = n + 2 + hold_of(i);
                end else if (m_run[i] && !m_fly[i] && n >= m_ready[i] && (!sm_q || m_pend[i])) begin
                    m_trace[i][m_hold[i]] = 1'b1;
                    if (sm_q) m_pend[i] = 0;
                    m_fly[i]   = 1;
                    m_latch[i] = n + 1;
                end
                if (act) begin
                    if (!m_run[i]) begin
                        m_run[i] = 1; m_hold[i] = 0; m_data[i][0] = 0; m_fly[i] = 0;
                        m_ready[i] = n + 1 + hold_of(i);
                    end else if (sm_q) begin
                        m_pend[i] = 1;
                    end
                end
            end
            if (act) press_at = -1;
            if (btn_q && !start_btn) press_at = n + 3;
            btn_q = start_btn;
            sm_q  = step_mode;
        end
    endtask

    always @(negedge clk) begin
        model_step(cyc);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("model_running[%0d]", i), 32'(o_run[i]), 32'(m_run[i]));
            check($sformatf("model_lap[%0d]", i),     32'(o_lap[i]), 32'(m_lap[i]));
            check($sformatf("model_trace[%0d]", i),   32'(o_trc[i]), 32'(m_trace[i]));
            check($sformatf("model_pins[%0d]", i),    32'(o_out[i]),
                  (int'(disp_sel) < S) ? 32'(m_data[i][disp_sel]) : 32'd0);
        end
    end

    task automatic wait_pos(input int c);
        do begin @(posedge clk); #2; end while (cyc < c);
    endtask
    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask
    task automatic press(output int t);
        @(posedge clk); #2;
        start_btn = 1'b0;
        t = cyc + 3;
        repeat (2) begin @(posedge clk); #2; end
        start_btn = 1'b1;
    endtask
    task automatic do_reset();
        @(posedge clk); #2; rst = 1'b1;
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #2; end
    endtask

    initial begin
        int t, t2, t3, t4, p2, p3;
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b0;
        wait_neg(cyc + 1);
        check("reset_running", 32'(if_a.running), 32'd0);
        check("reset_trace",   32'(if_a.trace_req), 32'd0);
        check("reset_lap",     32'(if_a.lap_cnt), 32'd0);

        // Free-run, default-style timing on instance a
        press(t);
        wait_neg(t);     check("inj_running", 32'(if_a.running), 32'd1);
                         check("inj_data0",   32'(if_a.output_pins), 32'd0);
                         check("inj_trace",   32'(if_a.trace_req), 32'd0);
        wait_neg(t + 1); check("req0_t1",     32'(if_a.trace_req), 32'b001);
        wait_neg(t + 3); check("req1_low_t3", 32'(if_a.trace_req), 32'b001);
        wait_neg(t + 4); check("req1_t4",     32'(if_a.trace_req), 32'b011);
        wait_neg(t + 7); check("req2_t7",     32'(if_a.trace_req), 32'b111);
                         check("lap0_t7",     32'(if_a.lap_cnt), 32'd0);
        wait_neg(t + 8); check("data0_t8",    32'(if_a.output_pins), 32'd3);
                         check("lap1_t8",     32'(if_a.lap_cnt), 32'd1);
        wait_pos(t + 10); disp_sel = 2'd1;
        wait_pos(t + 12); start_btn = 1'b0;
        wait_pos(t + 14); start_btn = 1'b1;
        wait_neg(t + 22); check("hold5_lap0",  32'(if_c.lap_cnt), 32'd0);
        wait_neg(t + 23); check("hold5_lap1",  32'(if_c.lap_cnt), 32'd1);
        wait_neg(t + 46); check("wrap_pre",    32'(if_b.output_pins), 32'd13);
        wait_neg(t + 47); check("wrap_zero",   32'(if_b.output_pins), 32'd0);
                          check("a_data1_16",  32'(if_a.output_pins), 32'd16);
                          check("a_lap5",      32'(if_a.lap_cnt), 32'd5);
                          check("hold5_lap2",  32'(if_c.lap_cnt), 32'd2);
                          check("hold5_data1", 32'(if_c.output_pins), 32'd4);
        wait_pos(t + 50); disp_sel = 2'd3;
        wait_neg(t + 51); check("sel3_a", 32'(if_a.output_pins), 32'd0);
                          check("sel3_c", 32'(if_c.output_pins), 32'd0);

        // Reset while req[1] is high
        do_reset();
        disp_sel = 2'd1;
        press(t2);
        wait_pos(t2 + 4);
        rst = 1'b1;
        #1;
        check("rst_running", 32'(if_a.running), 32'd0);
        check("rst_pins",    32'(if_a.output_pins), 32'd0);
        check("rst_trace",   32'(if_a.trace_req), 32'd0);
        check("rst_lap",     32'(if_a.lap_cnt), 32'd0);
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
        disp_sel = 2'd0;
        repeat (2) begin @(posedge clk); #2; end
        press(t3);
        wait_neg(t3);     check("restart_running", 32'(if_a.running), 32'd1);
                          check("restart_data0",   32'(if_a.output_pins), 32'd0);
                          check("restart_lap",     32'(if_a.lap_cnt), 32'd0);
        wait_neg(t3 + 8); check("restart_data0_t8", 32'(if_a.output_pins), 32'd3);
                          check("restart_lap_t8",   32'(if_a.lap_cnt), 32'd1);

        // Single-step mode
        @(posedge clk); #2; rst = 1'b1; step_mode = 1'b1; disp_sel = 2'd1;
        repeat (2) begin @(posedge clk); #2; end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #2; end
        press(t4);
        wait_neg(t4 + 100); check("step_idle_trace", 32'(if_a.trace_req), 32'd0);
                            check("step_idle_data1", 32'(if_a.output_pins), 32'd0);
                            check("step_idle_run",   32'(if_a.running), 32'd1);
        press(p2);
        wait_neg(p2 + 1);   check("step1_req0",  32'(if_a.trace_req), 32'b001);
                            check("step1_early", 32'(if_a.output_pins), 32'd0);
        wait_neg(p2 + 2);   check("step1_data1", 32'(if_a.output_pins), 32'd1);
                            check("step1_c",     32'(if_c.output_pins), 32'd1);
        wait_neg(p2 + 30);  check("step1_hold",  32'(if_a.trace_req), 32'b001);
        wait_pos(p2 + 31); disp_sel = 2'd2;
        press(p3);
        wait_neg(p3 + 2);   check("step2_data2", 32'(if_a.output_pins), 32'd2);
                            check("step2_trace", 32'(if_a.trace_req), 32'b011);
                            check("step2_c",     32'(if_c.output_pins), 32'd2);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/token_ring_counter.md
Name: token_ring_counter

Overview:
- Synchronous, parametrised successor to the three-stage asynchronous adder ring.
- STAGES stages sit in a ring and pass a single counting token over 4-phase req/ack links. Each stage adds STEP to the token value as it receives it.
- A debounced-by-sync start button injects the token. Free-run and single-step modes are supported.
- Per-stage sticky trace bits, a lap counter and a selectable display drive the board pins.

Parameters:
- WIDTH, 25: token data width; arithmetic is mod 2^WIDTH.
- DISPLAY_WIDTH, 8: width of output_pins; must be <= WIDTH.
- STAGES, 3: number of ring stages; must be >= 2.
- STEP, 1: value added by each stage on receive.
- HOLD_CYCLES, 0: cycles a stage holds the token before raising req.
- LAP_WIDTH, 8: lap counter width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start_btn  in  1  raw board button, active-low, asynchronous to clk.
- step_mode  in  1  0 = free-run, 1 = single-step.
- disp_sel  in  $clog2(STAGES)  selects which stage's data drives output_pins.
- output_pins  out  DISPLAY_WIDTH  data[disp_sel][WIDTH-1 -: DISPLAY_WIDTH].
- trace_req  out  STAGES  sticky; bit k is set on the first rise of req[k].
- lap_cnt  out  LAP_WIDTH  completed laps, wrapping.
- running  out  1  a token is present in the ring.

Behaviour:
- Reset (async, active-high):
  - All stages EMPTY; all req/ack low; all data 0; hold counters 0.
  - trace_req = 0, lap_cnt = 0, running = 0, advance_pending = 0.
  - Synchronizer flops reset to 1 (button released).
  - Reset mid-operation discards the token; the next start press restarts from data 0.
- Start:
  - start_btn passes through a 2-flop synchronizer; a falling edge is detected as sync_prev=1 and sync=0.
  - Edge with running=0: stage 0 enters HOLD with data[0]=0 on the next clk edge; running=1.
  - Edge with running=1 and step_mode=1: sets advance_pending.
  - Edge with running=1 and step_mode=0: ignored.
- Per-stage FSM for stage k (next stage j = (k+1) mod STAGES):
  - EMPTY: waits for req[prev]. When req[prev]=1, latches data[k] = data[prev]+STEP (mod 2^WIDTH), raises ack[prev], goes to ACKED.
  - ACKED: waits for req[prev]=0, then drops ack[prev], clears hold_cnt, goes to HOLD.
  - HOLD: increments hold_cnt until hold_cnt == HOLD_CYCLES. At that point, if step_mode=0 or advance_pending=1, raises req[k] and goes to REQ; raising req clears advance_pending.
  - REQ: waits for ack[k]=1, then drops req[k] and goes to EMPTY. data[k] is retained for display.
- Link and hop timing:
  - All req/ack are registered. Each link is 4-phase: req up, ack up, req down, ack down.
  - Hop latency from req[k] rising to req[j] rising is 3 + HOLD_CYCLES cycles (step_mode=0).
  - Lap latency is STAGES*(3+HOLD_CYCLES).
- lap_cnt increments, wrapping, in the cycle stage 0 latches data from stage STAGES-1.
- Exactly one token exists in the ring. Injection occurs only when running=0.
- step_mode changes take effect at the next HOLD-exit decision. advance_pending is ignored and holds its value while step_mode=0.
- output_pins is combinational from the data registers. disp_sel >= STAGES drives 0.
- trace_req bits are cleared only by rst.

Test Plan:
- Defaults, step_mode=0: reset, press start -> stage 0 HOLD with data 0; req[0]=1 at t+1; data[1]=1 at t+2; req[1]=1 at t+4; data[2]=2 at t+5; req[2]=1 at t+7; data[0]=3 and lap_cnt=1 at t+8; trace_req=3'b111.
- WIDTH=4, STEP=1: free-run for 16 hops -> token data returns to 0 (wrap), with no stuck req/ack.
- step_mode=1: press -> stage 0 holds, req[0] stays 0 for 100 cycles; second press -> exactly one hop, data[1]=1 and stage 1 holds; third press -> data[2]=2.
- HOLD_CYCLES=5: free-run -> req rises spaced exactly 8 cycles apart on successive stages; lap = 24 cycles.
- Assert rst while req[1]=1 -> outputs 0, running=0 immediately; press -> restart with data[0]=0 and lap_cnt=0.
- Free-run: extra presses during run -> no second token, hop timing unchanged; disp_sel=3 with STAGES=3 -> output_pins=0.
